fetch_unit_bp: RTL
==================

FETCH_UNIT_BP -- requirements
Module: fetch_unit_bp

Interface
REQ-001 SHALL have parameter BHT_IDX_W, default 6; BHT holds 2^BHT_IDX_W 2-bit counters.
REQ-002 SHALL have parameter FQ_DEPTH_W, default 3; fetch queue holds 2^FQ_DEPTH_W entries.
REQ-003 SHALL have one clock and asynchronous active-high reset: clk in 1, clock; rst in 1, async active-high reset.
REQ-004 SHALL have port rdy in 1: global enable; when low, all state holds.
REQ-005 SHALL have ports hit in 1 and ins in 32: icache hit and instruction word at addr_to_icache.
REQ-006 SHALL have port addr_to_icache out 32: equals current pc register.
REQ-007 SHALL have ports issue_valid out 1, issue_ready in 1: queue-head handshake (issue_ready = downstream RS/ROB/LSB not full).
REQ-008 SHALL have ports issue_pc out 32, issue_ins out 32, issue_pred_taken out 1, issue_pred_pc out 32: queue-head payload.
REQ-009 SHALL have ports clear in 1, new_pc in 32: ROB misprediction redirect.
REQ-010 SHALL have ports upt_en in 1, upt_pc in 32, upt_taken in 1: ROB branch-outcome update.

Function
REQ-011 SHALL fetch in a cycle iff rdy && hit && !clear && queue count < 2^FQ_DEPTH_W; a pop in the same cycle does not free a slot for that cycle's push.
REQ-012 SHALL index BHT with pc[BHT_IDX_W+1:2]; prediction taken iff counter[1] = 1.
REQ-013 On fetch, next pc SHALL be: ins[6:0]=1101111 (JAL) -> pc+J-imm, pred_taken=1; 1100011 (branch) -> predicted taken ? pc+B-imm : pc+4; 1100111 (JALR) -> pc+4, pred_taken=0; otherwise pc+4, pred_taken=0.
REQ-014 J-imm and B-imm SHALL be sign-extended to 32 bits, bit 0 = 0; pc arithmetic wraps modulo 2^32.
REQ-015 Fetch SHALL push {pc, ins, pred_taken, next pc} at the tail; next pc stored as pred_pc.
REQ-016 issue_valid SHALL equal (count != 0), driven from registers only; payload SHALL be the head entry.
REQ-017 Pop SHALL occur iff rdy && issue_valid && issue_ready && !clear; simultaneous push and pop leave count unchanged.
REQ-018 Head/tail pointers SHALL be FQ_DEPTH_W bits and wrap naturally; count SHALL be FQ_DEPTH_W+1 bits.
REQ-019 On rdy && clear: pc <= new_pc, head <= tail <= 0, count <= 0; clear overrides push and pop that cycle.
REQ-020 On rdy && upt_en: counter at upt_pc[BHT_IDX_W+1:2] SHALL saturating-increment if upt_taken, else saturating-decrement (bounds 00, 11); update applies even when clear is high.
REQ-021 Prediction read and update to the same index in one cycle: prediction SHALL use the pre-update counter value.
REQ-022 Fetch latency: instruction accepted at edge N SHALL be visible on issue_* after edge N if queue was empty (issue_valid high in cycle N+1).
REQ-023 When hit low, pc SHALL hold and no entry is pushed.

Reset
REQ-024 On rst assertion, asynchronously: pc = 0, head = tail = count = 0, issue_valid = 0, all BHT counters = 2'b10 (weakly taken).
REQ-025 Reset mid-operation SHALL discard all queue contents and BHT history; queue payload RAM needs no reset, issue_* payload SHALL be don't-care while issue_valid = 0.

Structure
REQ-026 Opcode constants (OP_BRANCH, OP_JAL, OP_JALR) and BHT init value SHALL live in the shared macros file.
REQ-027 BHT SHALL be a sub-module bht_2bit (parameter BHT_IDX_W; one read port, one update port, async reset).
REQ-028 Fetch queue and pc/predecode logic SHALL remain in fetch_unit_bp.

Verification
REQ-029 Reset, hit=1, ins=ADDI stream, issue_ready=1 -> addr_to_icache 0,4,8,...; issue_pc follows one cycle later, pred_taken=0, pred_pc=pc+4.
REQ-030 pc=0x10, ins=BEQ imm=-8, fresh BHT -> pred_taken=1, next pc 0x08; after two upt_taken=0 updates at upt_pc=0x10, same fetch -> pc 0x14.
REQ-031 issue_ready=0, hit=1 for 10 cycles, FQ_DEPTH_W=3 -> exactly 8 pushes, pc stalls, issue_valid stays 1; then issue_ready=1 -> 8 entries drain in order.
REQ-032 Queue holding 5 entries, clear=1 new_pc=0x100 with issue_ready=1 -> no pop, issue_valid=0 next cycle, addr_to_icache=0x100.
REQ-033 JAL imm=+0x20 at pc=0x40 -> next pc 0x60, pred_taken=1; JALR -> pc+4, pred_taken=0.
REQ-034 rdy=0 with hit, issue_ready, upt_en all high -> pc, queue, BHT unchanged; rst pulse mid-stream -> pc=0, issue_valid=0 immediately.

Source files
------------

// File: rtl/fetch_unit_bp_pkg.sv
// Purpose : shared opcode constants, BHT init value, fetch-queue entry type and immediate decoders.
// Latency : n/a (definitions only).
// Backpres: n/a.
package fetch_unit_bp_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Counters come out of reset weakly taken.
   localparam logic [1:0] BHT_INIT  = 2'b10;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        pred_taken;
      logic [31:0] pred_pc;
   } fq_ent_t;

   // JAL immediate: imm[20|10:1|11|19:12] in ins[31:12], sign-extended, bit 0 = 0.
   function automatic logic [31:0] j_imm(input logic [31:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   // Branch immediate: imm[12|10:5] in ins[31:25], imm[4:1|11] in ins[11:7].
   function automatic logic [31:0] b_imm(input logic [31:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/bht_2bit.sv
// Purpose : table of 2-bit saturating branch counters, one combinational read port, one update port.
// Latency : read is combinational; update lands on the next clk edge (same-cycle read sees old value).
// Backpres: none; caller gates upd_en.
// Ports   : clk/rst (async high), rd_idx -> rd_taken, upd_en/upd_idx/upd_taken.
module bht_2bit
   import fetch_unit_bp_pkg::*;
#(
   parameter int BHT_IDX_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BHT_IDX_W-1:0] rd_idx,
   output logic                 rd_taken,
   input  logic                 upd_en,
   input  logic [BHT_IDX_W-1:0] upd_idx,
   input  logic                 upd_taken
);

   localparam int BHT_SIZE = 1 << BHT_IDX_W;

   logic [1:0] cnt [BHT_SIZE];

   assign rd_taken = cnt[rd_idx][1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_SIZE; i++) begin
            cnt[i] <= BHT_INIT;
         end
      end else if (upd_en) begin
         if (upd_taken) begin
            if (cnt[upd_idx] != 2'b11) cnt[upd_idx] <= cnt[upd_idx] + 2'b01;
         end else begin
            if (cnt[upd_idx] != 2'b00) cnt[upd_idx] <= cnt[upd_idx] - 2'b01;
         end
      end
   end

endmodule

// File: rtl/fetch_unit_bp.sv
// Purpose : instruction fetch with BHT-driven predecode, feeding an in-order fetch queue.
// Latency : word accepted at edge N is on issue_* after edge N when the queue was empty.
// Backpres: fetch stalls (pc holds) while the queue is full; pop only on issue_ready; rdy=0 freezes all.
// Ports   : clk/rst, rdy; hit/ins from icache, addr_to_icache = pc; issue_* queue head handshake;
//           clear/new_pc redirect; upt_en/upt_pc/upt_taken branch outcome update.
module fetch_unit_bp
   import fetch_unit_bp_pkg::*;
#(
   parameter int BHT_IDX_W  = 6,
   parameter int FQ_DEPTH_W = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        hit,
   input  logic [31:0] ins,
   output logic [31:0] addr_to_icache,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [31:0] issue_pc,
   output logic [31:0] issue_ins,
   output logic        issue_pred_taken,
   output logic [31:0] issue_pred_pc,
   input  logic        clear,
   input  logic [31:0] new_pc,
   input  logic        upt_en,
   input  logic [31:0] upt_pc,
   input  logic        upt_taken
);

   localparam int FQ_DEPTH = 1 << FQ_DEPTH_W;
   localparam logic [FQ_DEPTH_W:0]   FQ_FULL = {1'b1, {FQ_DEPTH_W{1'b0}}};
   localparam logic [FQ_DEPTH_W-1:0] PTR_ONE = FQ_DEPTH_W'(1);
   localparam logic [FQ_DEPTH_W:0]   CNT_ONE = (FQ_DEPTH_W + 1)'(1);

   logic [31:0]           pc;
   logic [FQ_DEPTH_W-1:0] head;
   logic [FQ_DEPTH_W-1:0] tail;
   logic [FQ_DEPTH_W:0]   count;
   fq_ent_t               fq_mem [FQ_DEPTH];

   logic        bht_taken;
   logic        pred_taken;
   logic [31:0] next_pc;
   logic        do_push;
   logic        do_pop;
   fq_ent_t     push_ent;
   fq_ent_t     head_ent;

   // Only the index bits of upt_pc feed the BHT.
   logic unused_upt_bits;
   assign unused_upt_bits = &{1'b0, upt_pc[31:BHT_IDX_W+2], upt_pc[1:0]};

   bht_2bit #(.BHT_IDX_W(BHT_IDX_W)) u_bht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pc[BHT_IDX_W+1:2]),
      .rd_taken  (bht_taken),
      .upd_en    (rdy && upt_en),
      .upd_idx   (upt_pc[BHT_IDX_W+1:2]),
      .upd_taken (upt_taken)
   );

   // Predecode: only JAL and conditional branches redirect; JALR target is unknown here.
   always_comb begin
      pred_taken = 1'b0;
      next_pc    = pc + 32'd4;
      case (ins[6:0])
         OP_JAL: begin
            pred_taken = 1'b1;
            next_pc    = pc + j_imm(ins);
         end
         OP_BRANCH: begin
            pred_taken = bht_taken;
            if (bht_taken) next_pc = pc + b_imm(ins);
         end
         OP_JALR: begin
            pred_taken = 1'b0;
            next_pc    = pc + 32'd4;
         end
         default: begin
            pred_taken = 1'b0;
            next_pc    = pc + 32'd4;
         end
      endcase
   end

   // Fullness uses the pre-pop count, so a same-cycle pop never makes room for the push.
   assign do_push = rdy && hit && !clear && (count != FQ_FULL);
   assign do_pop  = rdy && (count != '0) && issue_ready && !clear;

   assign push_ent = '{pc: pc, ins: ins, pred_taken: pred_taken, pred_pc: next_pc};

   // Payload RAM carries no reset; it is only observed while count != 0.
   always_ff @(posedge clk) begin
      if (do_push) fq_mem[tail] <= push_ent;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy) begin
         if (clear) begin
            pc    <= new_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (do_push) begin
               pc   <= next_pc;
               tail <= tail + PTR_ONE;
            end
            if (do_pop) head <= head + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
         end
      end
   end

   assign head_ent         = fq_mem[head];
   assign addr_to_icache   = pc;
   assign issue_valid      = (count != '0);
   assign issue_pc         = head_ent.pc;
   assign issue_ins        = head_ent.ins;
   assign issue_pred_taken = head_ent.pred_taken;
   assign issue_pred_pc    = head_ent.pred_pc;

endmodule
